// File: rtl/tx_pkg.sv
// Shared transmit-chain types: sample format, LFSR width, 4-PAM levels, FSM states.
package tx_pkg;

  localparam int unsigned LFSR_W   = 22;
  localparam int unsigned SAMPLE_W = 18;

  // Signed 1s17 sample
  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Default 4-PAM level magnitudes: +0.25 and +0.75 in 1s17
  localparam sample_t LEVEL_A_DEF  = 18'sh08000;
  localparam sample_t LEVEL_3A_DEF = 18'sh18000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/pam4_gray_map.sv
// Combinational Gray 2-bit symbol to signed 4-PAM level map (shared with the RX slicer model).
module pam4_gray_map
  import tx_pkg::*;
#(
  parameter logic signed [SAMPLE_W-1:0] LEVEL_A  = LEVEL_A_DEF,
  parameter logic signed [SAMPLE_W-1:0] LEVEL_3A = LEVEL_3A_DEF
) (
  input  logic [1:0]                 sym,
  output logic signed [SAMPLE_W-1:0] level_c
);

  // Gray order: 00,01,11,10 walks the levels from most negative to most positive
  always_comb begin
    level_c = '0;
    unique case (sym)
      2'b00:   level_c = SAMPLE_W'(-LEVEL_3A);
      2'b01:   level_c = SAMPLE_W'(-LEVEL_A);
      2'b11:   level_c = LEVEL_A;
      default: level_c = LEVEL_3A;
    endcase
  end

endmodule

// File: rtl/pam4_mapper_upsampler.sv
// Samples the LFSR once per symbol, Gray-maps to 4-PAM and emits an upsampled stream.
module pam4_mapper_upsampler
  import tx_pkg::*;
#(
  parameter int unsigned                 UP         = 4,
  parameter logic signed [SAMPLE_W-1:0]  LEVEL_A    = LEVEL_A_DEF,
  parameter logic signed [SAMPLE_W-1:0]  LEVEL_3A   = LEVEL_3A_DEF,
  parameter logic [LFSR_W-1:0]           SEQ_MARK   = 22'h3FFFFE,
  parameter bit                          ZERO_STUFF = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [LFSR_W-1:0]          lfsr_in,
  output logic signed [SAMPLE_W-1:0] y_out,
  output logic                       sym_strobe,
  output logic                       seq_start,
  output logic [LFSR_W-1:0]          sym_count,
  output logic                       running
);

  localparam int unsigned PHASE_W = (UP > 2) ? $clog2(UP) : 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(UP - 1);

  state_t                       state;
  logic [PHASE_W-1:0]           phase;
  logic signed [SAMPLE_W-1:0]   level_c;
  logic                         is_mark_c;
  logic                         sym_edge_c;

  pam4_gray_map #(
    .LEVEL_A  (LEVEL_A),
    .LEVEL_3A (LEVEL_3A)
  ) u_map (
    .sym     (lfsr_in[1:0]),
    .level_c (level_c)
  );

  // A symbol is taken on phase 0 of RUN and on the IDLE->RUN edge itself
  always_comb begin
    is_mark_c  = (lfsr_in == SEQ_MARK);
    sym_edge_c = (state == IDLE) || (phase == '0);
  end

  // FSM, phase counter, registered sample stream and symbol counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      running    <= 1'b0;
      phase      <= '0;
      y_out      <= '0;
      sym_strobe <= 1'b0;
      seq_start  <= 1'b0;
      sym_count  <= '0;
    end else if (!enable) begin
      // Leaving or staying in IDLE abandons any partial symbol; count holds
      state      <= IDLE;
      running    <= 1'b0;
      phase      <= '0;
      y_out      <= '0;
      sym_strobe <= 1'b0;
      seq_start  <= 1'b0;
    end else begin
      state   <= RUN;
      running <= 1'b1;
      if (sym_edge_c) begin
        y_out      <= level_c;
        sym_strobe <= 1'b1;
        seq_start  <= is_mark_c;
        sym_count  <= is_mark_c ? '0 : sym_count + LFSR_W'(1);
        phase      <= PHASE_W'(1);
      end else begin
        sym_strobe <= 1'b0;
        seq_start  <= 1'b0;
        if (ZERO_STUFF) y_out <= '0;
        phase      <= (phase == PHASE_LAST) ? '0 : phase + PHASE_W'(1);
      end
    end
  end

endmodule
